corr_mac_engine: RTL and testbench

//  Sliding-window cross-correlator feeding the peak solver. Loads WIN reference samples,

---
 rtl/corr_pkg.sv | 30 +++
 rtl/corr_mac_unit.sv | 32 +++
 rtl/corr_mac_engine.sv | 138 +++++++++++++
 tb/tb_corr_mac_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared defaults, width helper and FSM state encoding for the sliding-window correlator.
package corr_pkg;

  localparam int SW_DEF    = 8;
  localparam int WIN_DEF   = 32;
  localparam int CORR_DEF  = 4980;
  localparam int LAG_W_DEF = 13;

  // Ceiling log2, usable in constant expressions.
  function automatic int corr_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int SUM_W_DEF = 2 * SW_DEF + corr_clog2(WIN_DEF);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_REF = 3'd1,
    FILL     = 3'd2,
    WAIT_SIG = 3'd3,
    MAC      = 3'd4,
    DONE     = 3'd5
  } corr_state_e;

endpackage

// File: rtl/corr_mac_unit.sv
// Multiply-accumulate unit: acc presents the running sum including the current a*b,
// so the final tap can be captured on the same edge it is accumulated.
module corr_mac_unit #(
  parameter int SW    = 8,
  parameter int SUM_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SW-1:0]    a,
  input  logic [SW-1:0]    b,
  output logic [SUM_W-1:0] acc
);

  logic [2*SW-1:0]  prod;
  logic [SUM_W-1:0] acc_q;

  assign prod = {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
  assign acc  = acc_q + SUM_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/corr_mac_engine.sv
// Sliding-window cross-correlator: loads WIN reference taps, streams signal samples and
// emits one correlation sum per lag through a single shared MAC.
// Build option CORR_KEEP_REF_EN: a start from DONE reuses the stored reference.
module corr_mac_engine
  import corr_pkg::*;
#(
  parameter int  SW    = SW_DEF,
  parameter int  WIN   = WIN_DEF,
  parameter int  CORR  = CORR_DEF,
  parameter int  LAG_W = LAG_W_DEF,
  localparam int SUM_W = 2 * SW + corr_clog2(WIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SW-1:0]    din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [SUM_W-1:0] sum_out,
  output logic             sum_valid,
  output logic [LAG_W-1:0] lag_idx,
  output logic             busy,
  output logic             done,
  output corr_state_e      state_dbg
);

  localparam int TAP_W = corr_clog2(WIN);

  corr_state_e      state, state_nxt;
  logic [SW-1:0]    ref_mem [WIN];
  logic [SW-1:0]    win_mem [WIN];
  logic [TAP_W-1:0] tap_cnt;
  logic [LAG_W-1:0] lag_cnt;
  logic [SUM_W-1:0] acc;
  logic             accept;
  logic             last_tap;
  logic             fill_last;
  logic             last_lag;
  logic             shift_en;

  // Handshake: din transfers on a rising edge where din_valid && din_ready; din_ready is
  // a function of state alone and never depends on din_valid.
  assign din_ready = (state == LOAD_REF) || (state == FILL) || (state == WAIT_SIG);
  assign accept    = din_valid && din_ready;
  assign last_tap  = (tap_cnt == TAP_W'(WIN - 1));
  assign fill_last = (tap_cnt == TAP_W'(WIN - 2));
  assign last_lag  = (lag_cnt == LAG_W'(CORR - 1));
  assign shift_en  = accept && ((state == FILL) || (state == WAIT_SIG));
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = LOAD_REF;
      LOAD_REF: if (accept && last_tap) state_nxt = FILL;
      FILL:     if (accept && fill_last) state_nxt = WAIT_SIG;
      WAIT_SIG: if (accept) state_nxt = MAC;
      MAC:      if (last_tap) state_nxt = last_lag ? DONE : WAIT_SIG;
      DONE: begin
`ifdef CORR_KEEP_REF_EN
        if (start) state_nxt = FILL;
`else
        if (start) state_nxt = LOAD_REF;
`endif
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      lag_cnt   <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      lag_idx   <= '0;
    end else begin
      state     <= state_nxt;
      sum_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            tap_cnt <= '0;
            lag_cnt <= '0;
          end
        end
        LOAD_REF: if (accept) tap_cnt <= last_tap ? '0 : tap_cnt + TAP_W'(1);
        FILL:     if (accept) tap_cnt <= fill_last ? '0 : tap_cnt + TAP_W'(1);
        WAIT_SIG: tap_cnt <= '0;
        MAC: begin
          if (last_tap) begin
            tap_cnt   <= '0;
            sum_out   <= acc;
            sum_valid <= 1'b1;
            lag_idx   <= lag_cnt;
            if (!last_lag) lag_cnt <= lag_cnt + LAG_W'(1);
          end else begin
            tap_cnt <= tap_cnt + TAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // win_mem[0] is the oldest sample; new samples enter at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) begin
        ref_mem[i] <= '0;
        win_mem[i] <= '0;
      end
    end else begin
      if ((state == LOAD_REF) && accept) ref_mem[tap_cnt] <= din;
      if (shift_en) begin
        for (int i = 0; i < WIN - 1; i++) win_mem[i] <= win_mem[i+1];
        win_mem[WIN-1] <= din;
      end
    end
  end

  corr_mac_unit #(
    .SW   (SW),
    .SUM_W(SUM_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(state == WAIT_SIG),
    .en (state == MAC),
    .a  (win_mem[tap_cnt]),
    .b  (ref_mem[tap_cnt]),
    .acc(acc)
  );

endmodule

// File: tb/tb_corr_mac_engine.sv
// Scoreboard bench for corr_mac_engine with CORR=8: drivers push expected sums, lags and
// strobe cycles; a negedge monitor pops and compares whenever sum_valid is seen.
module tb_corr_mac_engine;
  import corr_pkg::*;

  localparam int WIN  = 32;
  localparam int CORR = 8;
  localparam int NSIG = WIN - 1 + CORR;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [20:0] sum_out;
  logic        sum_valid;
  logic [12:0] lag_idx;
  logic        busy;
  logic        done;
  corr_state_e state_dbg;

  logic [20:0] exp_sum_q[$];
  logic [12:0] exp_lag_q[$];
  int          exp_cyc_q[$];

  int n_cmp;
  int n_fail;
  int cyc;
  int last_trig;
  logic prev_sv;

  corr_mac_engine #(.CORR(CORR)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .sum_out  (sum_out),
    .sum_valid(sum_valid),
    .lag_idx  (lag_idx),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flush_exp();
    exp_sum_q.delete();
    exp_lag_q.delete();
    exp_cyc_q.delete();
    last_trig = -1000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    din_valid = 1'b0;
    din = '0;
    repeat (2) @(negedge clk);
    flush_exp();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // reference / signal patterns and hand-derived sums
  function automatic logic [7:0] ref_val(input int kind, input int j);
    case (kind)
      0: return 8'd1;
      1: return 8'd255;
      2: return (j == 5) ? 8'd1 : 8'd0;
      default: return 8'd2;
    endcase
  endfunction

  function automatic logic [7:0] sig_val(input int kind, input int n);
    case (kind)
      0: return 8'd1;
      1: return 8'd255;
      default: return 8'(n);
    endcase
  endfunction

  function automatic logic [20:0] exp_sum(input int kind, input int k);
    case (kind)
      0: return 21'd32;
      1: return 21'd2080800;
      2: return 21'(k + 5);
      default: return 21'(64 * k + 992);
    endcase
  endfunction

  // driver: entered and left just after a negedge
  task automatic send_word(input logic [7:0] d, input bit gaps, input bit trig,
                           input logic [20:0] esum, input logic [12:0] elag);
    int waited;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        din_valid = 1'b0;
        @(negedge clk);
      end
    end
    din = d;
    din_valid = 1'b1;
    waited = 0;
    while (!din_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!din_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL din_ready_timeout: got 0 expected 1 (t=%0t)", $time);
      din_valid = 1'b0;
      return;
    end
    if (trig) begin
      exp_sum_q.push_back(esum);
      exp_lag_q.push_back(elag);
      exp_cyc_q.push_back(cyc + 1 + WIN);
      last_trig = cyc + 1;
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic load_ref(input int kind, input bit gaps);
    for (int j = 0; j < WIN; j++) send_word(ref_val(kind, j), gaps, 1'b0, '0, '0);
  endtask

  task automatic send_sig(input int kind, input bit gaps, input int count);
    for (int n = 0; n < count; n++) begin
      if (n >= WIN - 1)
        send_word(sig_val(kind, n), gaps, 1'b1, exp_sum(kind, n - (WIN - 1)), 13'(n - (WIN - 1)));
      else
        send_word(sig_val(kind, n), gaps, 1'b0, '0, '0);
    end
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (exp_sum_q.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (exp_sum_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_sum_q.size());
      flush_exp();
    end
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_din_ready"}, 32'(din_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_lag_hold"}, 32'(lag_idx), 32'(CORR - 1));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (sum_valid && prev_sv) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sum_valid_consecutive: got 1 expected 0 (t=%0t)", $time);
      end
      if (sum_valid) begin
        if (exp_sum_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_strobe: got lag %0d sum %0d expected none", lag_idx, sum_out);
        end else begin
          check("sum_out", 32'(sum_out), 32'(exp_sum_q.pop_front()));
          check("lag_idx", 32'(lag_idx), 32'(exp_lag_q.pop_front()));
          check("strobe_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end
      if (cyc >= last_trig && cyc < last_trig + WIN)
        check("din_ready_in_mac", 32'(din_ready), 32'd0);
    end
    prev_sv = sum_valid;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    prev_sv = 1'b0;
    last_trig = -1000;
    do_reset();

    // reset state
    check("rst_sum_out", 32'(sum_out), 32'd0);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_lag_idx", 32'(lag_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // test 1: all ones, continuous
    do_start();
    check("t1_busy", 32'(busy), 32'd1);
    load_ref(0, 1'b0);
    send_sig(0, 1'b0, NSIG);
    wait_drain();
    check_done("t1");
    check("t1_sum_hold", 32'(sum_out), 32'd32);

    // test 2: full scale
    do_reset();
    do_start();
    load_ref(1, 1'b0);
    send_sig(1, 1'b0, NSIG);
    wait_drain();
    check_done("t2");

    // test 3: impulse reference, ramp signal
    do_reset();
    do_start();
    load_ref(2, 1'b0);
    send_sig(2, 1'b0, NSIG);
    wait_drain();
    check_done("t3");

    // test 4: same with valid gaps
    do_reset();
    do_start();
    load_ref(2, 1'b1);
    send_sig(2, 1'b1, NSIG);
    wait_drain();
    check_done("t4");

    // test 5: reset in the middle of lag 3
    do_reset();
    do_start();
    load_ref(2, 1'b0);
    send_sig(2, 1'b0, WIN - 1 + 4);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_sum_out", 32'(sum_out), 32'd0);
    check("t5_sum_valid", 32'(sum_valid), 32'd0);
    check("t5_lag_idx", 32'(lag_idx), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_state", 32'(state_dbg), 32'(IDLE));
    flush_exp();
    @(negedge clk);
    rst = 1'b0;
    do_start();
    load_ref(2, 1'b0);
    send_sig(2, 1'b0, NSIG);
    wait_drain();
    check_done("t5");

    // test 6: restart from DONE
    do_start();
`ifdef CORR_KEEP_REF_EN
    send_sig(2, 1'b0, NSIG);
`else
    load_ref(3, 1'b0);
    send_sig(3, 1'b0, NSIG);
`endif
    wait_drain();
    check_done("t6");
    din = 8'd77;
    din_valid = 1'b1;
    repeat (5) @(negedge clk);
    din_valid = 1'b0;
    check("t6_ignored_done", 32'(done), 32'd1);
    check("t6_ignored_ready", 32'(din_ready), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
